matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 104 ++++++++++
 tb/tb_matrix_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Collects N*N signed elements (row-major, first element in the MSBs), presents the
// packed matrix to an external determinant unit, then captures and holds its result.
module matrix_loader #(
  parameter int DATA_W  = 8,
  parameter int N       = 5,
  parameter int DET_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic [N*N*DATA_W-1:0]    mat_out,
  output logic                     mat_valid,
  input  logic [DATA_W-1:0]        det_in,
  input  logic                     ovf_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_det,
  output logic                     res_ovf
);

  localparam int unsigned NE = N * N;
  localparam int unsigned CW = (NE > 1) ? $clog2(NE) : 1;
  localparam int unsigned LW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NE - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(DET_LAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, RESULT} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic [NE*DATA_W-1:0] mat_q, mat_d;
  logic [DATA_W-1:0]    det_q, det_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    mat_d     = mat_q;
    det_d     = det_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q == IDLE) || (state_q == LOAD);
    mat_valid = (state_q == COMPUTE);
    res_valid = (state_q == RESULT);
    accept    = in_valid && in_ready;

    if (accept) begin
      // Element slot selected by counter; constant slices keep the write decode static.
      for (int unsigned k = 0; k < NE; k++) begin
        if (cnt_q == CW'(k)) mat_d[(NE-1-k)*DATA_W +: DATA_W] = in_data;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        lat_d   = '0;
        state_d = COMPUTE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = LOAD;
      end
    end

    case (state_q)
      COMPUTE: begin
        if (lat_q == LAT_LAST) begin
          det_d   = det_in;
          ovf_d   = ovf_in;
          lat_d   = '0;
          state_d = RESULT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      RESULT: if (res_ready) state_d = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      mat_q   <= '0;
      det_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      mat_q   <= mat_d;
      det_q   <= det_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mat_out = mat_q;
  assign res_det = det_q;
  assign res_ovf = ovf_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: a directed cycle table for the reference stream, then randomized
// loads checked against an element-array model of the loader.
module tb_matrix_loader;
  localparam int DW = 8;
  localparam int N = 5;
  localparam int NE = N * N;
  localparam int DET_LAT = 2;
  localparam int MW = NE * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [MW-1:0] mat_out;
  logic          mat_valid;
  logic [DW-1:0] det_in;
  logic          ovf_in;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_det;
  logic          res_ovf;

  matrix_loader #(.DATA_W(DW), .N(N), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mat_out(mat_out), .mat_valid(mat_valid), .det_in(det_in), .ovf_in(ovf_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_det(res_det), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] model[NE];
  logic [DW-1:0] elems[NE];
  logic [DW-1:0] last_det;
  logic          last_ovf;

  task automatic chk_m(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_m(name, {{(MW-1){1'b0}}, act}, {{(MW-1){1'b0}}, exp});
  endtask

  task automatic chk_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_m(name, {{(MW-DW){1'b0}}, act}, {{(MW-DW){1'b0}}, exp});
  endtask

  function automatic logic [MW-1:0] pack();
    logic [MW-1:0] p;
    p = '0;
    for (int k = 0; k < NE; k++) p[MW-1-k*DW -: DW] = model[k];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk_b({tag, "_ready"}, in_ready, 1'b1);
    chk_b({tag, "_mvalid"}, mat_valid, 1'b0);
    chk_b({tag, "_rvalid"}, res_valid, 1'b0);
    chk_m({tag, "_mat"}, mat_out, pack());
  endtask

  task automatic load_partial(input int n);
    for (int k = 0; k < n; k++) begin
      chk_b("part_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = elems[k];
      step();
      model[k] = elems[k];
      chk_m("part_mat", mat_out, pack());
    end
    in_valid = 1'b0;
  endtask

  // Full transaction: load with random in_valid gaps, compute, hold result, release.
  task automatic load_and_check(input int pct, input logic [DW-1:0] det, input logic ovf,
                                input int hold);
    int   acc;
    int   cyc;
    logic v;
    acc = 0;
    cyc = 0;
    check_idle("pre");
    det_in = det;
    ovf_in = ovf;
    while (acc < NE && cyc < 1000) begin
      chk_b("ld_ready", in_ready, 1'b1);
      chk_b("ld_mvalid", mat_valid, 1'b0);
      v         = ($urandom_range(99) < pct);
      in_valid  = v;
      in_data   = v ? elems[acc] : DW'($urandom);
      res_ready = 1'($urandom_range(1));
      step();
      cyc++;
      if (v) begin
        model[acc] = elems[acc];
        acc++;
      end
      chk_m("ld_mat", mat_out, pack());
    end
    chk_v("ld_count", DW'(acc), DW'(NE));
    for (int c = 0; c < DET_LAT; c++) begin
      chk_b("cmp_mvalid", mat_valid, 1'b1);
      chk_b("cmp_ready", in_ready, 1'b0);
      chk_b("cmp_rvalid", res_valid, 1'b0);
      chk_m("cmp_mat", mat_out, pack());
      in_valid  = 1'($urandom_range(1));
      in_data   = DW'($urandom);
      res_ready = 1'($urandom_range(1));
      step();
    end
    for (int h = 0; h < hold; h++) begin
      chk_b("res_rvalid", res_valid, 1'b1);
      chk_v("res_det", res_det, det);
      chk_b("res_ovf", res_ovf, ovf);
      chk_b("res_mvalid", mat_valid, 1'b0);
      chk_b("res_inready", in_ready, 1'b0);
      res_ready = 1'b0;
      det_in    = DW'($urandom);
      ovf_in    = 1'($urandom_range(1));
      in_valid  = 1'($urandom_range(1));
      in_data   = DW'($urandom);
      step();
    end
    chk_b("rel_rvalid", res_valid, 1'b1);
    chk_v("rel_det", res_det, det);
    chk_b("rel_ovf", res_ovf, ovf);
    last_det  = res_det;
    last_ovf  = res_ovf;
    res_ready = 1'b1;
    in_valid  = 1'($urandom_range(1));
    step();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check_idle("post");
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rr;
    logic [DW-1:0] det;
    logic          ovf;
    logic          e_rdy;
    logic          e_mv;
    logic          e_rv;
    logic          chk_res;
    logic [DW-1:0] e_det;
    logic          e_ovf;
    logic          chk_mat;
  } row_t;

  function automatic row_t mk(input logic v, input logic [DW-1:0] d, input logic rr,
                              input logic [DW-1:0] det, input logic ovf, input logic e_rdy,
                              input logic e_mv, input logic e_rv, input logic chk_res,
                              input logic [DW-1:0] e_det, input logic e_ovf, input logic chk_mat);
    row_t r;
    r.v = v; r.d = d; r.rr = rr; r.det = det; r.ovf = ovf;
    r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_rv = e_rv;
    r.chk_res = chk_res; r.e_det = e_det; r.e_ovf = e_ovf; r.chk_mat = chk_mat;
    return r;
  endfunction

  int stream[NE] = '{1,1,1,1, 1,1,1,1, 0,1,1,2, 1,1,1,0, 0,1,1,1, 1,1,0,1, 1};
  int elems_b[5] = '{2, 3, 2, 5, 6};
  localparam logic [MW-1:0] STREAM_MAT =
    200'h01010101_01010101_00010102_01010100_00010101_01010001_01;

  row_t tbl[34];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; det_in = '0; ovf_in = 1'b0; res_ready = 1'b0;
    for (int k = 0; k < NE; k++) model[k] = '0;

    #12;
    chk_b("rst_ready", in_ready, 1'b1);
    chk_b("rst_mvalid", mat_valid, 1'b0);
    chk_b("rst_rvalid", res_valid, 1'b0);
    chk_m("rst_mat", mat_out, '0);
    chk_v("rst_det", res_det, '0);
    chk_b("rst_ovf", res_ovf, 1'b0);
    rst = 1'b1;
    step();

    for (int k = 0; k < NE; k++)
      tbl[k] = mk(1'b1, DW'(stream[k]), 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[25] = mk(1'b1, 8'hAA, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[26] = mk(1'b1, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 27; k < 32; k++)
      tbl[k] = mk(1'(k), 8'h77, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    tbl[32] = mk(1'b1, 8'h77, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    tbl[33] = mk(1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    for (int r = 0; r < 34; r++) begin
      in_valid = tbl[r].v; in_data = tbl[r].d; res_ready = tbl[r].rr;
      det_in = tbl[r].det; ovf_in = tbl[r].ovf;
      chk_b($sformatf("tbl%0d_ready", r), in_ready, tbl[r].e_rdy);
      chk_b($sformatf("tbl%0d_mvalid", r), mat_valid, tbl[r].e_mv);
      chk_b($sformatf("tbl%0d_rvalid", r), res_valid, tbl[r].e_rv);
      if (tbl[r].chk_res) begin
        chk_v($sformatf("tbl%0d_det", r), res_det, tbl[r].e_det);
        chk_b($sformatf("tbl%0d_ovf", r), res_ovf, tbl[r].e_ovf);
      end
      if (tbl[r].chk_mat) chk_m($sformatf("tbl%0d_mat", r), mat_out, STREAM_MAT);
      step();
    end
    in_valid = 1'b0; res_ready = 1'b0;
    for (int k = 0; k < NE; k++) model[k] = DW'(stream[k]);

    for (int k = 0; k < NE; k++) elems[k] = DW'($urandom);
    load_and_check(50, DW'($urandom), 1'($urandom_range(1)), 3);

    for (int k = 0; k < NE; k++) elems[k] = DW'($urandom);
    load_partial(12);
    #3 rst = 1'b0;
    #1;
    for (int k = 0; k < NE; k++) model[k] = '0;
    chk_b("arst_ready", in_ready, 1'b1);
    chk_b("arst_mvalid", mat_valid, 1'b0);
    chk_b("arst_rvalid", res_valid, 1'b0);
    chk_m("arst_mat", mat_out, '0);
    chk_v("arst_det", res_det, '0);
    chk_b("arst_ovf", res_ovf, 1'b0);
    #2 rst = 1'b1;
    step();
    for (int k = 0; k < NE; k++) elems[k] = DW'($urandom);
    load_and_check(70, DW'($urandom), 1'($urandom_range(1)), 2);

    for (int k = 0; k < NE; k++) elems[k] = DW'(k * 3 + 1);
    load_and_check(100, 8'h11, 1'b0, 0);
    for (int k = 0; k < NE; k++) elems[k] = (k < 5) ? DW'(elems_b[k]) : DW'(k % 7);
    load_and_check(100, DW'(-90), 1'b1, 0);
    chk_v("neg90_det", last_det, 8'hA6);
    chk_b("neg90_ovf", last_ovf, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
